// File: rtl/riscuin_pkg.sv
// riscuin_pkg: shared fetch-unit types and constants
package riscuin_pkg;
   localparam int INSTR_WIDTH = 32;
   typedef enum logic [1:0] {IDLE, REQ, DRAIN, HALT} fetch_state_e;
endpackage

// File: rtl/riscuin_sync_fifo.sv
// riscuin_sync_fifo: synchronous FIFO with flush and registered occupancy count
module riscuin_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush_i,
   input  logic                    push_i,
   input  logic [WIDTH-1:0]        data_i,
   input  logic                    pop_i,
   output logic [WIDTH-1:0]        data_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  count_o
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] rd_q, wr_q;
   logic [AW:0] cnt_q;
   logic do_push, do_pop;
   assign do_pop = pop_i && cnt_q != '0;
   assign do_push = push_i && (cnt_q != (AW+1)'(DEPTH) || do_pop);
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         rd_q <= '0;
         wr_q <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_q] <= data_i;
   end
   assign data_o = mem_q[rd_q];
   assign empty_o = cnt_q == '0;
   assign count_o = cnt_q;
endmodule

// File: rtl/riscuin_fetch_unit.sv
// riscuin_fetch_unit: instruction prefetcher, one outstanding memory request,
// redirect flushes the buffer and discards any in-flight word.
module riscuin_fetch_unit
   import riscuin_pkg::*;
#(
   parameter int INSTR_ADDR_WIDTH = 8,
   parameter int FIFO_DEPTH = 4,
   parameter logic [INSTR_ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic                        mem_req,
   output logic [INSTR_ADDR_WIDTH-1:0] mem_addr,
   input  logic                        mem_ack,
   input  logic [INSTR_WIDTH-1:0]      mem_rdata,
   input  logic                        redirect,
   input  logic [INSTR_ADDR_WIDTH-1:0] redirect_pc,
   output logic                        instr_valid,
   input  logic                        instr_ready,
   output logic [INSTR_WIDTH-1:0]      instr,
   output logic [INSTR_ADDR_WIDTH-1:0] instr_pc,
   output logic                        pc_end
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   fetch_state_e state_q;
   logic [INSTR_ADDR_WIDTH-1:0] fetch_pc_q, mem_addr_q;
   logic pc_end_q, push, pop, empty, space_after_push;
   logic [CW-1:0] count;
   logic [INSTR_ADDR_WIDTH+INSTR_WIDTH-1:0] head;
   assign pop = instr_valid && instr_ready;
   assign push = state_q == REQ && mem_ack && !redirect;
   assign space_after_push = int'(count) + 1 - int'(pop) < FIFO_DEPTH;
   assign mem_req = state_q == REQ || state_q == DRAIN;
   assign mem_addr = mem_addr_q;
   assign instr_valid = !empty;
   assign {instr_pc, instr} = head;
   assign pc_end = pc_end_q;
   riscuin_sync_fifo #(
      .WIDTH(INSTR_ADDR_WIDTH + INSTR_WIDTH),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk(clk),
      .rst(rst),
      .flush_i(redirect),
      .push_i(push),
      .data_i({fetch_pc_q, mem_rdata}),
      .pop_i(pop),
      .data_o(head),
      .empty_o(empty),
      .count_o(count)
   );
   // fetch_pc_q doubles as the pending redirect target while draining
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         fetch_pc_q <= RESET_PC;
         mem_addr_q <= RESET_PC;
         pc_end_q <= 1'b0;
      end else begin
         pc_end_q <= 1'b0;
         if (redirect) fetch_pc_q <= redirect_pc;
         case (state_q)
            IDLE: begin
               if (redirect || int'(count) < FIFO_DEPTH) begin
                  state_q <= REQ;
                  mem_addr_q <= redirect ? redirect_pc : fetch_pc_q;
               end
            end
            REQ: begin
               if (mem_ack && redirect) mem_addr_q <= redirect_pc;
               else if (mem_ack) begin
                  fetch_pc_q <= fetch_pc_q + 1'b1;
                  mem_addr_q <= fetch_pc_q + 1'b1;
                  state_q <= fetch_pc_q == '1 ? HALT : space_after_push ? REQ : IDLE;
               end else if (redirect) state_q <= DRAIN;
            end
            DRAIN: begin
               if (mem_ack) begin
                  state_q <= REQ;
                  mem_addr_q <= redirect ? redirect_pc : fetch_pc_q;
               end
            end
            HALT: begin
               if (redirect) begin
                  state_q <= REQ;
                  mem_addr_q <= redirect_pc;
               end else pc_end_q <= count == CW'(pop);
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_riscuin_fetch_unit.sv
// tb_riscuin_fetch_unit: vector, directed and randomized checks of the fetch unit
module tb_riscuin_fetch_unit;
   localparam int AW = 8;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, mem_req, mem_ack, redirect, instr_valid, instr_ready, pc_end;
   logic [AW-1:0] mem_addr, redirect_pc, instr_pc;
   logic [31:0] mem_rdata, instr;
   logic s_rst, s_req, s_ack, s_redirect, s_valid, s_ready, s_end;
   logic [4:0] s_addr, s_rpc, s_pc;
   logic [31:0] s_rdata, s_instr;
   int checks = 0, failures = 0;
   bit busy;
   int wait_n;
   logic [AW-1:0] held;
   typedef struct {int ack, rdy, e_req, e_addr, e_valid, e_pc;} vec_t;
   vec_t tv [9];

   riscuin_fetch_unit #(.INSTR_ADDR_WIDTH(AW), .FIFO_DEPTH(4), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .instr_pc(instr_pc), .pc_end(pc_end)
   );
   riscuin_fetch_unit #(.INSTR_ADDR_WIDTH(5), .FIFO_DEPTH(4), .RESET_PC(5'h1C)) dut_small (
      .clk(clk), .rst(s_rst), .mem_req(s_req), .mem_addr(s_addr), .mem_ack(s_ack),
      .mem_rdata(s_rdata), .redirect(s_redirect), .redirect_pc(s_rpc),
      .instr_valid(s_valid), .instr_ready(s_ready), .instr(s_instr),
      .instr_pc(s_pc), .pc_end(s_end)
   );

   function automatic logic [31:0] word(input int a);
      return 32'hC0DE_0000 | 32'(a);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; mem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0; busy = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   // memory responder: acks each request after 0..lat_max cycles, checks address stability
   task automatic respond(input int lat_max);
      mem_ack = 1'b0;
      if (!mem_req) busy = 1'b0;
      else begin
         if (!busy) begin
            busy = 1'b1;
            wait_n = int'($urandom_range(lat_max, 0));
            held = mem_addr;
         end else chk("addr_stable", 32'(mem_addr), 32'(held));
         if (wait_n == 0) begin
            mem_ack = 1'b1;
            mem_rdata = word(int'(mem_addr));
            busy = 1'b0;
         end else wait_n--;
      end
   endtask

   initial begin
      int acks, exp_pc, acc, nfetch, npop;
      bit redir_prev;
      rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
      s_rst = 1'b1; s_ack = 1'b0; s_rdata = '0; s_redirect = 1'b0; s_rpc = '0; s_ready = 1'b0;
      // {ack, ready, expected req, addr, valid, pc}: ack one cycle after each request
      tv[0] = '{0, 1, 1, 0, 0, 0};
      tv[1] = '{1, 1, 1, 0, 0, 0};
      tv[2] = '{0, 1, 1, 1, 1, 0};
      tv[3] = '{1, 1, 1, 1, 0, 0};
      tv[4] = '{0, 1, 1, 2, 1, 1};
      tv[5] = '{1, 1, 1, 2, 0, 0};
      tv[6] = '{0, 1, 1, 3, 1, 2};
      tv[7] = '{1, 1, 1, 3, 0, 0};
      tv[8] = '{0, 1, 1, 4, 1, 3};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("vec%0d_req", i), 32'(mem_req), 32'(tv[i].e_req));
         chk($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(tv[i].e_addr));
         chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(tv[i].e_valid));
         if (tv[i].e_valid != 0) begin
            chk($sformatf("vec%0d_pc", i), 32'(instr_pc), 32'(tv[i].e_pc));
            chk($sformatf("vec%0d_instr", i), instr, word(tv[i].e_pc));
         end
         mem_ack = tv[i].ack != 0;
         mem_rdata = word(int'(mem_addr));
         instr_ready = tv[i].rdy != 0;
         tick();
      end
      mem_ack = 1'b0;

      // buffer fill with decoder stalled
      do_reset();
      acks = 0;
      repeat (12) begin
         respond(0);
         if (mem_ack) acks++;
         tick();
      end
      mem_ack = 1'b0;
      chk("full_acks", 32'(acks), 4);
      chk("full_req", 32'(mem_req), 0);
      chk("full_head_pc", 32'(instr_pc), 0);
      mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      tick(); tick();
      mem_ack = 1'b0;
      chk("spurious_req", 32'(mem_req), 0);
      chk("spurious_head", instr, word(0));
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk("pop_head_pc", 32'(instr_pc), 1);
      acks = 0;
      repeat (8) begin
         respond(0);
         if (mem_ack) acks++;
         tick();
      end
      mem_ack = 1'b0;
      chk("refill_acks", 32'(acks), 1);
      chk("refill_req", 32'(mem_req), 0);
      chk("pc_end_idle", 32'(pc_end), 0);

      // redirect with delayed ack, retargeted while draining
      do_reset();
      instr_ready = 1'b1;
      chk("drain_req0", 32'(mem_req), 1);
      redirect = 1'b1; redirect_pc = 8'h40;
      tick();
      chk("drain_valid", 32'(instr_valid), 0);
      chk("drain_addr_hold", 32'(mem_addr), 0);
      redirect_pc = 8'h20;
      tick();
      redirect = 1'b0;
      chk("drain_req1", 32'(mem_req), 1);
      chk("drain_addr_hold2", 32'(mem_addr), 0);
      tick();
      mem_ack = 1'b1; mem_rdata = word(0);
      tick();
      mem_ack = 1'b0;
      chk("drain_new_addr", 32'(mem_addr), 32'h20);
      chk("drain_no_stale", 32'(instr_valid), 0);
      mem_ack = 1'b1; mem_rdata = word(32'h20);
      tick();
      mem_ack = 1'b0;
      chk("drain_head_pc", 32'(instr_pc), 32'h20);
      chk("drain_head_instr", instr, word(32'h20));

      // redirect coincident with ack
      do_reset();
      mem_ack = 1'b1; mem_rdata = word(0); redirect = 1'b1; redirect_pc = 8'h10;
      tick();
      mem_ack = 1'b0; redirect = 1'b0;
      chk("coinc_req", 32'(mem_req), 1);
      chk("coinc_addr", 32'(mem_addr), 32'h10);
      chk("coinc_valid", 32'(instr_valid), 0);

      // reset with a request outstanding, ack arriving during reset
      do_reset();
      rst = 1'b1;
      tick();
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      mem_ack = 1'b1; mem_rdata = word(0);
      tick();
      chk("rst_ack_valid", 32'(instr_valid), 0);
      chk("rst_pc_end", 32'(pc_end), 0);
      mem_ack = 1'b0; rst = 1'b0;
      tick();
      chk("rst_rel_req", 32'(mem_req), 1);
      chk("rst_rel_addr", 32'(mem_addr), 0);
      chk("rst_rel_valid", 32'(instr_valid), 0);

      // end of address space on the 5-bit instance
      s_rst = 1'b0; s_ready = 1'b1;
      tick();
      nfetch = 0; npop = 0;
      repeat (10) begin
         s_ack = s_req;
         s_rdata = word(int'(s_addr));
         if (s_req) begin
            chk("halt_fetch_addr", 32'(s_addr), 32'(28 + nfetch));
            nfetch++;
         end
         if (s_valid) begin
            chk("halt_pop_pc", 32'(s_pc), 32'(28 + npop));
            npop++;
         end
         tick();
      end
      s_ack = 1'b0;
      chk("halt_nfetch", 32'(nfetch), 4);
      chk("halt_npop", 32'(npop), 4);
      chk("halt_pc_end", 32'(s_end), 1);
      chk("halt_req", 32'(s_req), 0);
      s_redirect = 1'b1; s_rpc = 5'h00;
      tick();
      s_redirect = 1'b0;
      chk("halt_clear_end", 32'(s_end), 0);
      chk("halt_clear_req", 32'(s_req), 1);
      chk("halt_clear_addr", 32'(s_addr), 0);

      // random traffic against an in-order stream model
      do_reset();
      exp_pc = 0; acc = 0; redir_prev = 1'b0;
      repeat (400) begin
         if (redir_prev) chk("rand_flush_valid", 32'(instr_valid), 0);
         respond(3);
         instr_ready = $urandom_range(1, 0) == 1;
         redirect = $urandom_range(15, 0) == 0;
         redirect_pc = 8'($urandom_range(127, 0));
         if (instr_valid && instr_ready) begin
            chk("rand_pc", 32'(instr_pc), 32'(exp_pc));
            chk("rand_instr", instr, word(exp_pc));
            exp_pc++;
            acc++;
         end
         if (redirect) exp_pc = int'(redirect_pc);
         redir_prev = redirect;
         tick();
      end
      mem_ack = 1'b0; redirect = 1'b0;
      chk("rand_progress", 32'(acc > 20), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
